// File: rtl/fp_add_arbiter.sv
// Purpose: round-robin arbiter sharing one combinational FP32 adder among N_REQ clients.
// Latency: request handshake to rsp_valid is ADD_LAT+1 cycles; one operation in flight.
// Backpressure: requests stall while busy; the response holds until the owner's rsp_ready.
//
// Ports:
//   i_clk, i_reset          clock (rising edge), asynchronous active-low reset
//   i_req_valid/o_req_ready per-requester request handshake, ready is one-hot or zero
//   i_req_a/i_req_b         packed operands, requester i at [32*i +: 32]
//   o_rsp_valid/i_rsp_ready per-requester response handshake, valid is one-hot or zero
//   o_rsp_data              shared result word, zero outside the response phase
//   o_add_go/o_add_num1/o_add_num2/i_add_result  adder interface, operands zero when idle
//   o_busy                  high whenever an operation is in flight
//
// Build option: define FP_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// the default build uses round-robin starting after the last granted requester.
module fp_add_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADD_LAT = 1,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N_REQ-1:0]     i_req_valid,
    output logic [N_REQ-1:0]     o_req_ready,
    input  logic [32*N_REQ-1:0]  i_req_a,
    input  logic [32*N_REQ-1:0]  i_req_b,
    output logic [N_REQ-1:0]     o_rsp_valid,
    input  logic [N_REQ-1:0]     i_rsp_ready,
    output logic [31:0]          o_rsp_data,
    output logic                 o_add_go,
    output logic [31:0]          o_add_num1,
    output logic [31:0]          o_add_num2,
    input  logic [31:0]          i_add_result,
    output logic                 o_busy
);

    localparam int               CNT_W    = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ADD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_last_grant;
    logic [ID_W-1:0]   r_owner;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_op_a;
    logic [31:0]       r_op_b;
    logic [31:0]       r_res;

    logic              w_win_vld;
    logic [ID_W-1:0]   w_win;
    logic [N_REQ-1:0]  w_win_oh;
    logic [31:0]       w_sel_a;
    logic [31:0]       w_sel_b;
    int                w_dist;
    int                w_best_dist;
    logic              w_handshake;

    // Winner search: every valid requester gets a distance from the search
    // start point and the smallest distance wins. Round-robin starts just
    // after last_grant (so last_grant = N_REQ-1 starts at 0); fixed priority
    // uses the raw index as the distance.
    always_comb begin
        w_win_vld   = 1'b0;
        w_win       = '0;
        w_win_oh    = '0;
        w_dist      = 0;
        w_best_dist = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef FP_ARB_FIXED_PRIO_EN
            w_dist = i;
`else
            w_dist = (i - int'(r_last_grant) - 1 + N_REQ) % N_REQ;
`endif
            if (i_req_valid[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_win_vld   = 1'b1;
                w_win       = ID_W'(i);
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_sel_a = i_req_a[32*i +: 32];
                w_sel_b = i_req_b[32*i +: 32];
            end
        end
    end

    // Ready is also gated by reset so every output reads zero while reset is
    // held, even though the reset state is IDLE.
    assign w_handshake = (r_state == ST_IDLE) && w_win_vld && i_reset;

    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = '0;
        o_rsp_valid = '0;
        o_rsp_data  = '0;
        o_add_go    = 1'b0;
        o_add_num1  = '0;
        o_add_num2  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_handshake) begin
                    o_req_ready = w_win_oh;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                o_add_go   = 1'b1;
                o_add_num1 = r_op_a;
                o_add_num2 = r_op_b;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                o_rsp_valid[r_owner] = 1'b1;
                o_rsp_data           = r_res;
                if (i_rsp_ready[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_busy = (r_state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= ID_W'(N_REQ - 1);
            r_owner      <= '0;
            r_cnt        <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_res        <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_handshake) begin
                        r_op_a  <= w_sel_a;
                        r_op_b  <= w_sel_b;
                        r_owner <= w_win;
                        r_cnt   <= CNT_INIT;
                    end
                end
                ST_EXEC: begin
                    // Operands stay put for ADD_LAT cycles; the sum is sampled
                    // on the last of them.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_res <= i_add_result;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready[r_owner]) begin
                        r_last_grant <= r_owner;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one combinational single-precision FP adder (IEEE_SP_FP_ADDER_NOPIPE or equivalent) among N_REQ requesters.
- Round-robin arbitration with valid/ready on both request and response sides.
- Registers operands into the adder, waits ADD_LAT cycles, captures the sum and returns it to the owning requester.
- Sits between FP clients and the adder instance; one operation in flight at a time.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ADD_LAT, 1, cycles operands are held on the adder before the result is sampled (>=1; allows multicycle-path timing).
- ID_W, $clog2(N_REQ), width of the owner index.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_a  in  32*N_REQ  operand 1, requester i at [32*i+:32].
- req_b  in  32*N_REQ  operand 2, same packing.
- rsp_valid  out  N_REQ  result valid to owner; one-hot or zero.
- rsp_ready  in  N_REQ  per-requester result accept.
- rsp_data  out  32  result word, shared by all requesters.
- add_go  out  1  high while the adder is being exercised.
- add_num1  out  32  registered operand 1 to adder.
- add_num2  out  32  registered operand 2 to adder.
- add_result  in  32  adder combinational result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=N_REQ-1, owner=0, cnt=0.
  - op_a, op_b and res_reg cleared to 0.
  - All outputs are 0.
- IDLE:
  - Winner g = first i with req_valid[i], searching from last_grant+1 modulo N_REQ.
  - req_ready[g]=1 combinationally, and only for g.
  - On handshake: op_a<=req_a[g], op_b<=req_b[g], owner<=g, cnt<=ADD_LAT-1, go to EXEC.
  - No valid request: stay in IDLE.
- EXEC:
  - add_go=1; add_num1/add_num2 = op_a/op_b, stable for the whole state.
  - cnt!=0: decrement cnt.
  - cnt==0: res_reg<=add_result, go to RESP.
- RESP:
  - rsp_valid[owner]=1, rsp_data=res_reg.
  - On rsp_ready[owner]=1: last_grant<=owner, go to IDLE.
  - rsp_data and rsp_valid hold stable under backpressure, for any number of cycles.
- req_ready is 0 in EXEC and RESP. Requests are never accepted while busy.
- Outside RESP, rsp_data=0. Outside EXEC, add_num1/add_num2=0.
- Latency, req handshake to rsp_valid: ADD_LAT+1 cycles. Minimum issue interval: ADD_LAT+2 cycles.
- Requester inputs:
  - req_valid may drop without a handshake; no penalty.
  - rsp_ready of non-owners is ignored.
- Arithmetic:
  - The block never inspects or modifies data; rsp_data equals add_result sampled at the final EXEC cycle.
  - Operand order is preserved: req_a to add_num1.
- Wrap-around: last_grant=N_REQ-1 makes the search start at requester 0.
- Reset in EXEC or RESP: the operation is discarded, no response is produced, and the FSM returns to the reset state.

Optional Feature:
- Macro: FP_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index with req_valid wins. last_grant is still tracked but ignored.
- Undefined: round-robin as specified above.

Test Plan:
- Single request, ADD_LAT=1:
  - Stimulus: after reset, req 0 sends a=0x3F800000, b=0x3F800000.
  - Response: req_ready[0] pulses in cycle 0; add_go high in cycle 1; rsp_valid[0] in cycle 2 with rsp_data=0x40000000.
- Round-robin fairness:
  - Stimulus: all 4 req_valid held high, rsp_ready all 1.
  - Response: grants in order 0,1,2,3,0, spaced 3 cycles apart. Each rsp_data matches the adder model, e.g. req 2 with 2.0+2.0 returns 0x40800000.
- Backpressure:
  - Stimulus: rsp_ready[1]=0 for 5 cycles in RESP while req 0 is valid.
  - Response: rsp_valid[1] and rsp_data stay stable; req_ready stays 0; req 0 is granted only after the rsp_ready[1] handshake.
- Multicycle:
  - Stimulus: ADD_LAT=3, single request.
  - Response: add_go high exactly 3 cycles with operands stable; rsp_valid appears 4 cycles after the req handshake.
- Reset mid-operation:
  - Stimulus: drive reset=0 during EXEC.
  - Response: all outputs 0 immediately, without waiting for a clock edge. After release, no stale rsp_valid; the next grant goes to the lowest valid index.
- Fixed priority:
  - Stimulus: build with FP_ARB_FIXED_PRIO_EN defined; req 0 and req 3 continuously valid.
  - Response: req 0 always wins and req 3 is never granted. Without the macro, grants alternate 0,3,0,3.
